// File: rtl/display_scanout_if.sv
// Shared pixel type and the scanout bus between the frame-store display port,
// the renderer handshake and the display PHY.
package display_scanout_pkg;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

interface display_scanout_if;
  logic [display_scanout_pkg::ADDR_W-1:0] address_a_x;
  logic [display_scanout_pkg::ADDR_W-1:0] address_a_y;
  display_scanout_pkg::pixel_t            data_a;
  logic                                   switch_buffer;
  logic                                   swap_request;
  logic                                   swap_ack;
  display_scanout_pkg::pixel_t            pixel_out;
  logic                                   hsync;
  logic                                   vsync;
  logic                                   video_active;
  logic                                   vblank;

  modport master (
    output address_a_x, address_a_y, switch_buffer, swap_ack,
           pixel_out, hsync, vsync, video_active, vblank,
    input  data_a, swap_request
  );

  modport slave (
    input  address_a_x, address_a_y, switch_buffer, swap_ack,
           pixel_out, hsync, vsync, video_active, vblank,
    output data_a, swap_request
  );
endinterface

// File: rtl/display_scanout.sv
// Raster timing generator and display-port sweeper; realigns read data with
// sync/active and flips the frame buffers only at the start of vertical blanking.
module display_scanout
  import display_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  display_scanout_if.master    bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW       = $clog2(H_TOTAL + 1);
  localparam int unsigned VW       = $clog2(V_TOTAL + 1);
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pending_q, pending_d;

  logic          active1_q, hsync1_q, vsync1_q;
  pixel_t        pixel_q;
  logic          hsync_q, vsync_q, active_q;

  logic          active0_c, hsync0_c, vsync0_c, at_switch_c, switch_c;

  // Raster counters: v advances on every h wrap, both wrap together at frame end.
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      if (v_q == VW'(V_TOTAL - 1)) begin
        v_d = '0;
      end else begin
        v_d = v_q + VW'(1);
      end
    end
  end

  // Stage 0 decode straight from the counters.
  always_comb begin
    active0_c   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    hsync0_c    = (h_q >= HW'(HS_START)) && (h_q < HW'(HS_END));
    vsync0_c    = (v_q >= VW'(VS_START)) && (v_q < VW'(VS_END));
    at_switch_c = (h_q == '0) && (v_q == VW'(V_ACTIVE));
  end

  // A request landing on the switch point itself is honoured in the same cycle;
  // anything that fires the flip is consumed, so only a later request re-arms.
  always_comb begin
    switch_c  = reset && at_switch_c && (pending_q || bus.swap_request);
    pending_d = pending_q || bus.swap_request;
    if (switch_c) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      h_q       <= '0;
      v_q       <= '0;
      pending_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      pending_q <= pending_d;
    end
  end

  // Stage 1 holds timing while the frame store returns data; stage 2 drives the PHY.
  always_ff @(posedge clock) begin
    if (!reset) begin
      active1_q <= 1'b0;
      hsync1_q  <= ~SYNC_ACTIVE;
      vsync1_q  <= ~SYNC_ACTIVE;
      pixel_q   <= '0;
      hsync_q   <= ~SYNC_ACTIVE;
      vsync_q   <= ~SYNC_ACTIVE;
      active_q  <= 1'b0;
    end else begin
      active1_q <= active0_c;
      hsync1_q  <= hsync0_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync1_q  <= vsync0_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      pixel_q   <= active1_q ? bus.data_a : '0;
      hsync_q   <= hsync1_q;
      vsync_q   <= vsync1_q;
      active_q  <= active1_q;
    end
  end

  assign bus.address_a_x   = active0_c ? ADDR_W'(h_q) : '0;
  assign bus.address_a_y   = active0_c ? ADDR_W'(v_q) : '0;
  assign bus.vblank        = (v_q >= VW'(V_ACTIVE));
  assign bus.switch_buffer = switch_c;
  assign bus.swap_ack      = switch_c;
  assign bus.pixel_out     = pixel_q;
  assign bus.hsync         = hsync_q;
  assign bus.vsync         = vsync_q;
  assign bus.video_active  = active_q;

endmodule

// File: doc/display_scanout.md
# display_scanout

Display-side consumer of the double-buffered frame store. Generates raster timing and sweeps the read-only display port of the buffer mux, one address per clock. Realigns the one-cycle read data with the delayed sync and active signals. Exchanges a swap handshake with the renderer so the buffers flip only at the start of vertical blanking, never mid-frame.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (≤1024)
- H_FRONT, 16, horizontal front porch clocks
- H_SYNC, 96, hsync pulse clocks
- H_BACK, 48, horizontal back porch clocks
- V_ACTIVE, 480, visible lines per frame (≤512)
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch lines
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync

Ports:
- clock  in  1  pixel clock; one clock; reset is synchronous and active-low
- reset  in  1  synchronous active-low reset
- address_a_x  out  10  display-port read column
- address_a_y  out  10  display-port read row
- data_a  in  pixel_t  read data, stable one cycle after address
- switch_buffer  out  1  one-cycle pulse that flips the front/back buffers
- swap_request  in  1  renderer level request: back buffer complete
- swap_ack  out  1  one-cycle pulse, coincident with switch_buffer
- pixel_out  out  pixel_t  pixel to the display PHY
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_active  out  1  pixel_out is visible
- vblank  out  1  high while v_count ≥ V_ACTIVE (stage 0, not delayed)

## Operation
- Two counters. h_count runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters. v_count runs 0..V_TOTAL-1 and increments when h_count wraps. Both wrap to 0 together at the end of the frame.
- Stage 0 (counter cycle):
  - active0 = h_count<H_ACTIVE && v_count<V_ACTIVE.
  - address_a_x/y = h_count/v_count when active0, otherwise 0.
  - hsync0 is asserted for h_count in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync0 is asserted for v_count in the same construction using the V parameters.
- Stage 1: register active0, hsync0 and vsync0. data_a for the stage-0 address is valid in this cycle.
- Stage 2 (output registers):
  - pixel_out <= active1 ? data_a : '0.
  - hsync, vsync and video_active <= their stage-1 values.
- Swap handshake:
  - swap_pending is set on any cycle with swap_request=1.
  - At the switch point (h_count==0, v_count==V_ACTIVE, i.e. the first blanking line), if swap_pending or swap_request is 1: assert switch_buffer and swap_ack for exactly that cycle, and clear swap_pending.
  - A swap_request held high through the ack cycle is consumed. A new swap requires swap_request high after the ack cycle.
  - Multiple requests within one frame merge into one swap.
  - No request means no switch_buffer for that frame.
- The block does not track which physical buffer is front. It only issues flips.
- At most one switch_buffer per frame.

## Timing
- Reset (reset==0 at a clock edge) forces:
  - h_count=0, v_count=0, swap_pending=0
  - all pipeline registers clear
  - pixel_out='0, video_active=0, switch_buffer=0, swap_ack=0
  - hsync=vsync=~SYNC_ACTIVE
- address_a_x/y and vblank are combinational from the counters, so they read 0/0/0 while held in reset.
- First clock after reset release: counters at (0,0), address (0,0).
- Latency: counter state at cycle n appears on pixel_out, hsync, vsync and video_active at cycle n+2. Sync and data stay exactly aligned.
- switch_buffer is issued at counter (0,V_ACTIVE). The last active read, at (H_ACTIVE-1, V_ACTIVE-1), is H_TOTAL-H_ACTIVE+1 cycles earlier, so no in-flight read crosses the flip.
- Reset mid-frame: the frame is abandoned. Counters restart at (0,0) and a pending swap is dropped. The renderer must re-request.
- A swap_request arriving on the switch-point cycle itself is honoured in that same cycle.

## Test plan
- Reset held 5 cycles, then released:
  - during reset, every output is at its reset value and hsync=vsync=1.
  - after release, address (0,0) at cycle 0, then (1,0) at cycle 1.
- Free-run one frame with defaults:
  - 800 clocks per line and 525 lines.
  - hsync low for 96 clocks, starting 658 clocks after the line's address-x=0 cycle (656+2).
  - vsync low for 2 lines.
  - video_active high for 640×480 cycles.
- Latency: preload pixel (x=5, y=3)=0xA5 and drive data_a from a 1-cycle model. pixel_out=0xA5 exactly 2 cycles after address (5,3), with video_active=1.
- Swap:
  - Pulse swap_request for 1 cycle at (100,200). Exactly one switch_buffer/swap_ack pulse at (0,480), none in the next frame.
  - Hold swap_request high continuously. One pulse per frame, each at (0,480).
- Request on the switch-point cycle only: swap_request=1 solely at (0,480) gives switch_buffer=1 in that same cycle.
- Reset mid-frame at (300,250) with a swap pending: counters restart at (0,0) and no switch_buffer occurs at the next (0,480).
